receptor_ascii_torreta: RTL and testbench

//  Serial receiver/parser for turret telemetry frames "CDU,CDU#" (angle, distance).

---
 rtl/receptor_ascii_torreta.sv | 175 +++++++++++++++++
 tb/tb_receptor_ascii_torreta.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/receptor_ascii_torreta.sv
// Serial receiver for turret telemetry frames "CDU,CDU#": 7 data bits, even parity, 2 stop bits.
// Decodes angle and distance into BCD digits, reports a valid frame with pronto and rejects with erro.
module receptor_ascii_torreta #(
    parameter int CICLOS_BIT = 434,
    parameter int N_CICLOS   = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [3:0] centena_angulo,
    output logic [3:0] dezena_angulo,
    output logic [3:0] unidade_angulo,
    output logic [3:0] centena,
    output logic [3:0] dezena,
    output logic [3:0] unidade,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    // estado   | meaning
    // INICIAL  | idle, waiting for a falling edge on the line
    // START    | timing to the middle of the start bit
    // DADOS    | sampling the 7 data bits, LSB first
    // PARIDADE | sampling the even-parity bit
    // STOP1    | sampling the first stop bit
    // STOP2    | sampling the second stop bit, character complete
    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP1    = 4'd4,
        STOP2    = 4'd5
    } estado_t;

    localparam logic [N_CICLOS-1:0] MEIO_BIT  = N_CICLOS'(CICLOS_BIT / 2 - 1);
    localparam logic [N_CICLOS-1:0] BIT_CHEIO = N_CICLOS'(CICLOS_BIT - 1);

    estado_t             estado, proximo;
    logic                sinc_a, sinc_b, linha_ant;
    logic                borda_desc, amostra;
    logic                carrega_meio, char_fim;
    logic [N_CICLOS-1:0] timer;
    logic [2:0]          cont_bits;
    logic [6:0]          dado;
    logic                erro_char;
    logic                char_ok, char_err;
    logic [2:0]          indice;
    logic                formato_ok;
    logic [3:0]          est_ca, est_da, est_ua, est_c, est_d, est_u;

    assign borda_desc = linha_ant & ~sinc_b;
    assign amostra    = (timer == '0);

    always_ff @(posedge clock) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            INICIAL:  if (borda_desc) proximo = START;
            START:    if (amostra) proximo = sinc_b ? INICIAL : DADOS;
            DADOS:    if (amostra && cont_bits == 3'd6) proximo = PARIDADE;
            PARIDADE: if (amostra) proximo = STOP1;
            STOP1:    if (amostra) proximo = STOP2;
            STOP2:    if (amostra) proximo = INICIAL;
            default:  proximo = INICIAL;
        endcase
    end

    always_comb begin
        carrega_meio = (estado == INICIAL) && borda_desc;
        char_fim     = (estado == STOP2) && amostra;
        db_estado    = estado;
    end

    assign char_ok  = char_fim && !erro_char && sinc_b;
    assign char_err = char_fim && !char_ok;

    // Character datapath: synchronizer, bit timer, shift register and error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sinc_a    <= 1'b1;
            sinc_b    <= 1'b1;
            linha_ant <= 1'b1;
            timer     <= '0;
            cont_bits <= '0;
            dado      <= '0;
            erro_char <= 1'b0;
        end else begin
            sinc_a    <= entrada_serial;
            sinc_b    <= sinc_a;
            linha_ant <= sinc_b;
            if (carrega_meio)
                timer <= MEIO_BIT;
            else if (estado != INICIAL)
                timer <= amostra ? BIT_CHEIO : timer - 1'b1;
            if (estado == START)
                cont_bits <= '0;
            else if (estado == DADOS && amostra)
                cont_bits <= cont_bits + 3'd1;
            if (estado == DADOS && amostra)
                dado <= {sinc_b, dado[6:1]};
            if (estado == START)
                erro_char <= 1'b0;
            else if (estado == PARIDADE && amostra)
                erro_char <= ^{dado, sinc_b};
            else if (estado == STOP1 && amostra && !sinc_b)
                erro_char <= 1'b1;
        end
    end

    always_comb begin
        formato_ok = (dado >= 7'h30) && (dado <= 7'h39);
        if (indice == 3'd3)      formato_ok = (dado == 7'h2C);
        else if (indice == 3'd7) formato_ok = (dado == 7'h23);
    end

    // Frame parser: digits are staged and only copied out once the '#' arrives.
    always_ff @(posedge clock) begin
        if (!reset) begin
            indice         <= '0;
            est_ca         <= '0;
            est_da         <= '0;
            est_ua         <= '0;
            est_c          <= '0;
            est_d          <= '0;
            est_u          <= '0;
            centena_angulo <= '0;
            dezena_angulo  <= '0;
            unidade_angulo <= '0;
            centena        <= '0;
            dezena         <= '0;
            unidade        <= '0;
            pronto         <= 1'b0;
            erro           <= 1'b0;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            if (char_err) begin
                erro   <= 1'b1;
                indice <= '0;
            end else if (char_ok) begin
                if (!formato_ok) begin
                    erro   <= 1'b1;
                    indice <= '0;
                end else if (indice == 3'd7) begin
                    centena_angulo <= est_ca;
                    dezena_angulo  <= est_da;
                    unidade_angulo <= est_ua;
                    centena        <= est_c;
                    dezena         <= est_d;
                    unidade        <= est_u;
                    pronto         <= 1'b1;
                    indice         <= '0;
                end else begin
                    unique case (indice)
                        3'd0:    est_ca <= dado[3:0];
                        3'd1:    est_da <= dado[3:0];
                        3'd2:    est_ua <= dado[3:0];
                        3'd4:    est_c  <= dado[3:0];
                        3'd5:    est_d  <= dado[3:0];
                        3'd6:    est_u  <= dado[3:0];
                        default: ;
                    endcase
                    indice <= indice + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_receptor_ascii_torreta.sv
// Bench for receptor_ascii_torreta: table of frames sent over the serial line, with a
// scoreboard queue of expected pronto/erro events checked as the DUT produces them.
module tb_receptor_ascii_torreta;

    localparam int CB = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [3:0] centena_angulo, dezena_angulo, unidade_angulo;
    logic [3:0] centena, dezena, unidade;
    logic       pronto, erro;
    logic [3:0] db_estado;

    receptor_ascii_torreta #(.CICLOS_BIT(CB), .N_CICLOS(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (rx),
        .centena_angulo (centena_angulo),
        .dezena_angulo  (dezena_angulo),
        .unidade_angulo (unidade_angulo),
        .centena        (centena),
        .dezena         (dezena),
        .unidade        (unidade),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_erro;
        logic [23:0] digs;
    } evento_t;

    typedef struct {
        string       txt;
        int          flip_par;
        int          bad_stop;
        logic [15:0] erro_mask;
        bit          exp_pronto;
        logic [23:0] exp_digs;
    } vec_t;

    evento_t     fila[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic [23:0] modelo = '0;
    logic [23:0] ultimo = '0;
    vec_t        tabela[10];

    function automatic logic [23:0] saida();
        return {centena_angulo, dezena_angulo, unidade_angulo, centena, dezena, unidade};
    endfunction

    task automatic falha(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        errors++;
        if (errors <= 30)
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CB) @(negedge clock);
    endtask

    task automatic send_char(input logic [7:0] c, input bit flip, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(c[i]);
        send_bit((^c[6:0]) ^ flip);
        send_bit(!bad_stop);
        send_bit(1'b1);
    endtask

    task automatic push_ev(input bit is_erro, input logic [23:0] digs);
        evento_t e;
        e.is_erro = is_erro;
        e.digs    = digs;
        fila.push_back(e);
    endtask

    task automatic send_frame(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0, 1'b0);
    endtask

    always @(negedge clock) begin
        evento_t ev;
        if (mon_on) begin
            if (pronto && erro) falha("pronto_e_erro", 32'd1, 32'd0);
            if (!reset) begin
                modelo = '0;
            end else begin
                if (pronto || erro) begin
                    checks++;
                    if (fila.size() == 0) begin
                        falha("evento_inesperado", {30'd0, pronto, erro}, 32'd0);
                    end else begin
                        ev = fila.pop_front();
                        if (ev.is_erro != erro) begin
                            falha("tipo_evento_erro", {31'd0, erro}, {31'd0, ev.is_erro});
                        end else if (pronto) begin
                            checks++;
                            if (saida() != ev.digs) falha("digitos_pronto", {8'd0, saida()}, {8'd0, ev.digs});
                            modelo = ev.digs;
                        end
                    end
                end
                checks++;
                if (saida() != modelo) falha("estabilidade_saida", {8'd0, saida()}, {8'd0, modelo});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tabela[0] = '{"090,045#",  -1, -1, 16'h0000, 1'b1, 24'h090045};
        tabela[1] = '{"180,123#",  -1, -1, 16'h0000, 1'b1, 24'h180123};
        tabela[2] = '{"000,007#",  -1, -1, 16'h0000, 1'b1, 24'h000007};
        tabela[3] = '{"0090,045#",  0, -1, 16'h0001, 1'b1, 24'h090045};
        tabela[4] = '{"09A,045#",  -1, -1, 16'h008C, 1'b0, 24'h000000};
        tabela[5] = '{"357,246#",  -1, -1, 16'h0000, 1'b1, 24'h357246};
        tabela[6] = '{"12#",       -1, -1, 16'h0004, 1'b0, 24'h000000};
        tabela[7] = '{"999,000#",  -1, -1, 16'h0000, 1'b1, 24'h999000};
        tabela[8] = '{"5",         -1,  0, 16'h0001, 1'b0, 24'h000000};
        tabela[9] = '{"100,200#",  -1, -1, 16'h0000, 1'b1, 24'h100200};

        repeat (5) @(negedge clock);
        checks++; if (saida() != 24'h0) falha("reset_digitos", {8'd0, saida()}, 32'd0);
        checks++; if (pronto !== 1'b0) falha("reset_pronto", {31'd0, pronto}, 32'd0);
        checks++; if (erro !== 1'b0) falha("reset_erro", {31'd0, erro}, 32'd0);
        checks++; if (db_estado != 4'd0) falha("reset_estado", {28'd0, db_estado}, 32'd0);
        reset  = 1'b1;
        mon_on = 1'b1;
        repeat (20) @(negedge clock);

        // Vectors go out back-to-back, with no idle gap between characters.
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < tabela[v].txt.len(); i++) begin
                if (tabela[v].erro_mask[i]) push_ev(1'b1, 24'h0);
                if (tabela[v].exp_pronto && i == tabela[v].txt.len() - 1)
                    push_ev(1'b0, tabela[v].exp_digs);
                send_char(tabela[v].txt[i], i == tabela[v].flip_par, i == tabela[v].bad_stop);
            end
            if (tabela[v].exp_pronto) ultimo = tabela[v].exp_digs;
            checks++;
            if (saida() != ultimo) falha($sformatf("vetor_%0d_saida", v), {8'd0, saida()}, {8'd0, ultimo});
            checks++;
            if (fila.size() != 0) falha($sformatf("vetor_%0d_eventos_pendentes", v), fila.size(), 32'd0);
        end

        // Short low glitch on an idle line must be ignored.
        repeat (30) @(negedge clock);
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        checks++; if (db_estado != 4'd0) falha("glitch_estado", {28'd0, db_estado}, 32'd0);
        checks++; if (saida() != ultimo) falha("glitch_saida", {8'd0, saida()}, {8'd0, ultimo});

        // Reset in the middle of the 5th character of a frame.
        send_frame("123,");
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (20) @(negedge clock);
        checks++; if (saida() != 24'h0) falha("reset_meio_digitos", {8'd0, saida()}, 32'd0);
        checks++; if (db_estado != 4'd0) falha("reset_meio_estado", {28'd0, db_estado}, 32'd0);
        checks++; if (pronto || erro) falha("reset_meio_pulsos", {30'd0, pronto, erro}, 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        push_ev(1'b0, 24'h011022);
        send_frame("011,022#");

        for (int k = 0; k < 300 && fila.size() != 0; k++) @(negedge clock);
        repeat (20) @(negedge clock);
        checks++; if (fila.size() != 0) falha("eventos_finais", fila.size(), 32'd0);
        checks++; if (saida() != 24'h011022) falha("saida_final", {8'd0, saida()}, 32'h011022);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
